// File: rtl/i2c_slave_regs.sv
// I2C slave exposing sixteen 8-bit registers (write: addr, reg index, data...; read: addr+R, data...).
// Build option: define AUTO_INC_EN to advance the register pointer after every data byte.
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter logic [7:0] REG_INIT   = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic       wr_valid,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_t;

  state_t      state, state_n;
  logic [1:0]  scl_sync, sda_sync;
  logic        scl_prev, sda_prev;
  logic        scl_q, sda_q;
  logic        scl_rise, scl_fall, start_cond, stop_cond;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  shreg, shreg_n;
  logic        sda_oe, sda_oe_n;
  logic        ack_rise, ack_rise_n;
  logic        rw, rw_n;
  logic [3:0]  ptr, ptr_n, ptr_inc;
  logic        busy_n, wr_valid_n, reg_we;
  logic [3:0]  wr_addr_n;
  logic [7:0]  wr_data_n, rx_byte;
  logic [7:0]  regs [16];

  assign sda = sda_oe ? 1'b0 : 1'bz;

  assign scl_q      = scl_sync[1];
  assign sda_q      = sda_sync[1];
  assign scl_rise   = scl_q & ~scl_prev;
  assign scl_fall   = ~scl_q & scl_prev;
  assign start_cond = scl_q & scl_prev & sda_prev & ~sda_q;
  assign stop_cond  = scl_q & scl_prev & ~sda_prev & sda_q;
  assign rx_byte    = {shreg[6:0], sda_q};

`ifdef AUTO_INC_EN
  assign ptr_inc = ptr + 4'd1;
`else
  assign ptr_inc = ptr;
`endif

  // Bus synchronizers plus one more stage for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
      scl_prev <= scl_q;
      sda_prev <= sda_q;
    end
  end

  // Next-state logic; ACK states drive low on the first SCL fall and finish on the second.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    sda_oe_n   = sda_oe;
    ack_rise_n = ack_rise;
    rw_n       = rw;
    ptr_n      = ptr;
    busy_n     = busy;
    reg_we     = 1'b0;
    wr_valid_n = 1'b0;
    wr_addr_n  = wr_addr;
    wr_data_n  = wr_data;
    if (stop_cond) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else if (start_cond) begin
      state_n    = ADDR;
      bit_cnt_n  = 3'd7;
      sda_oe_n   = 1'b0;
      ack_rise_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sda_oe_n = 1'b0;
        end
        ADDR: begin
          if (scl_rise) begin
            shreg_n = rx_byte;
            if (bit_cnt == 3'd0) begin
              if (rx_byte[7:1] == SLAVE_ADDR) begin
                state_n    = ADDR_ACK;
                busy_n     = 1'b1;
                rw_n       = rx_byte[0];
                ack_rise_n = 1'b0;
              end else begin
                state_n = WAIT_STOP;
                busy_n  = 1'b0;
              end
            end else begin
              bit_cnt_n = bit_cnt - 3'd1;
            end
          end else begin
            shreg_n = shreg;
          end
        end
        ADDR_ACK, REG_ACK, WDATA_ACK: begin
          if (scl_fall && !ack_rise) begin
            sda_oe_n = 1'b1;
          end else if (scl_rise) begin
            ack_rise_n = 1'b1;
          end else if (scl_fall) begin
            sda_oe_n   = 1'b0;
            ack_rise_n = 1'b0;
            bit_cnt_n  = 3'd7;
            if (state == ADDR_ACK && rw) begin
              state_n  = RDATA;
              shreg_n  = {regs[ptr][6:0], 1'b0};
              sda_oe_n = ~regs[ptr][7];
            end else if (state == ADDR_ACK) begin
              state_n = REG;
            end else begin
              state_n = WDATA;
            end
          end else begin
            ack_rise_n = ack_rise;
          end
        end
        REG: begin
          if (scl_rise) begin
            shreg_n = rx_byte;
            if (bit_cnt == 3'd0) begin
              ptr_n      = rx_byte[3:0];
              state_n    = REG_ACK;
              ack_rise_n = 1'b0;
            end else begin
              bit_cnt_n = bit_cnt - 3'd1;
            end
          end else begin
            shreg_n = shreg;
          end
        end
        WDATA: begin
          if (scl_rise) begin
            shreg_n = rx_byte;
            if (bit_cnt == 3'd0) begin
              reg_we     = 1'b1;
              wr_valid_n = 1'b1;
              wr_addr_n  = ptr;
              wr_data_n  = rx_byte;
              ptr_n      = ptr_inc;
              state_n    = WDATA_ACK;
              ack_rise_n = 1'b0;
            end else begin
              bit_cnt_n = bit_cnt - 3'd1;
            end
          end else begin
            shreg_n = shreg;
          end
        end
        RDATA: begin
          if (scl_rise) begin
            if (bit_cnt == 3'd0) begin
              state_n    = RDATA_ACK;
              ack_rise_n = 1'b0;
            end else begin
              bit_cnt_n = bit_cnt - 3'd1;
            end
          end else if (scl_fall) begin
            sda_oe_n = ~shreg[7];
            shreg_n  = {shreg[6:0], 1'b0};
          end else begin
            shreg_n = shreg;
          end
        end
        RDATA_ACK: begin
          if (scl_fall && !ack_rise) begin
            sda_oe_n = 1'b0;
          end else if (scl_rise) begin
            if (!sda_q) begin
              ack_rise_n = 1'b1;
            end else begin
              state_n = WAIT_STOP;
              busy_n  = 1'b0;
            end
          end else if (scl_fall) begin
            ack_rise_n = 1'b0;
            ptr_n      = ptr_inc;
            shreg_n    = {regs[ptr_inc][6:0], 1'b0};
            sda_oe_n   = ~regs[ptr_inc][7];
            bit_cnt_n  = 3'd7;
            state_n    = RDATA;
          end else begin
            ack_rise_n = ack_rise;
          end
        end
        WAIT_STOP: begin
          sda_oe_n = 1'b0;
        end
        default: begin
          state_n  = IDLE;
          sda_oe_n = 1'b0;
        end
      endcase
    end
  end

  // State, datapath and register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bit_cnt  <= 3'd7;
      shreg    <= 8'h00;
      sda_oe   <= 1'b0;
      ack_rise <= 1'b0;
      rw       <= 1'b0;
      ptr      <= 4'd0;
      busy     <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= 4'd0;
      wr_data  <= 8'h00;
      for (int i = 0; i < 16; i++) regs[i] <= REG_INIT;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      sda_oe   <= sda_oe_n;
      ack_rise <= ack_rise_n;
      rw       <= rw_n;
      ptr      <= ptr_n;
      busy     <= busy_n;
      wr_valid <= wr_valid_n;
      wr_addr  <= wr_addr_n;
      wr_data  <= wr_data_n;
      if (reg_we) regs[ptr] <= rx_byte;
    end
  end

endmodule

// File: doc/i2c_slave_regs.md
I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

Interface
REQ-001 The block SHALL have parameter SLAVE_ADDR, default 7'h50, the 7-bit device address it answers to.
REQ-002 The block SHALL have parameter REG_INIT, default 8'h00, the reset value of every register.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock, with all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port scl, input, 1 bit: the I2C clock from the master.
REQ-006 The block SHALL have port sda, inout, 1 bit: open-drain data; it is driven only as 0, otherwise high-Z.
REQ-007 The block SHALL have port wr_valid, output, 1 bit: a one-clk pulse when a data byte is written to a register.
REQ-008 The block SHALL have port wr_addr, output, 4 bits: the register index of the last write.
REQ-009 The block SHALL have port wr_data, output, 8 bits: the data of the last write.
REQ-010 The block SHALL have port busy, output, 1 bit: high from an addressed START until STOP.

Function
REQ-011 scl and sda SHALL pass through 2-flop synchronizers; all edge detection SHALL use the synchronized copies; clk SHALL be at least 16x the SCL rate.
REQ-012 START SHALL be sda falling while scl is high; STOP SHALL be sda rising while scl is high; both SHALL be detected in any state, including mid-byte.
REQ-013 Received bits SHALL be sampled on scl rising; slave-driven sda SHALL change only on the clk after scl falling.
REQ-014 The FSM states SHALL be IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK and WAIT_STOP.
REQ-015 START SHALL go to ADDR with the bit counter at 7; a repeated START is treated identically; STOP SHALL go to IDLE and release sda.
REQ-016 In ADDR, 8 bits SHALL be shifted MSB first; if [7:1]==SLAVE_ADDR the FSM SHALL go to ADDR_ACK, otherwise to WAIT_STOP with no ACK.
REQ-017 In ADDR_ACK, sda SHALL be pulled low for the 9th SCL period; then the FSM SHALL go to REG if R/W=0, or to RDATA if R/W=1, with the shift register loaded from regs[ptr].
REQ-018 In REG, the 8-bit byte SHALL be received and ptr SHALL be set to byte[3:0] (bits [7:4] ignored); the byte SHALL be ACKed in REG_ACK; the FSM SHALL then go to WDATA.
REQ-019 In WDATA, after 8 bits regs[ptr] SHALL be updated, wr_valid SHALL pulse once, and wr_addr/wr_data SHALL update on the same clk; the byte SHALL be ACKed in WDATA_ACK and the FSM SHALL then return to WDATA.
REQ-020 In RDATA, the slave SHALL drive regs[ptr] MSB first (a 1 bit is sda released), then release sda in RDATA_ACK.
REQ-021 In RDATA_ACK, a master ACK (sda=0 at scl rising) SHALL reload and go to RDATA; a NACK SHALL go to WAIT_STOP.
REQ-022 In WAIT_STOP, sda SHALL be ignored and released until START or STOP.
REQ-023 If START/STOP occurs mid-byte, the partial byte SHALL be discarded, with no register write and no wr_valid.
REQ-024 busy SHALL be set on entering ADDR_ACK and cleared on STOP or on entering WAIT_STOP.

Reset
REQ-025 On reset the block SHALL go to IDLE; sda SHALL be released (high-Z); wr_valid, busy, wr_addr and wr_data SHALL be 0; ptr SHALL be 0; all 16 registers SHALL be REG_INIT; the synchronizers SHALL be set to 1.
REQ-026 Reset asserted mid-transfer SHALL abort immediately; after release the block SHALL ignore the bus until the next START.

Configuration
REQ-027 With AUTO_INC_EN defined, ptr SHALL increment mod 16 after each WDATA byte and after each ACKed RDATA byte (index 15 wraps to 0).
REQ-028 Without AUTO_INC_EN, ptr SHALL stay fixed for the whole transaction, so successive bytes hit the same register.

Verification
REQ-029 Write 0x50+W, reg 0x03, data 0xA5, STOP -> three ACKs; one wr_valid with wr_addr=3 and wr_data=0xA5; busy low after STOP.
REQ-030 Write reg 0x03, repeated START, 0x50+R, master NACK -> the read byte SHALL be 0xA5; sda released after NACK.
REQ-031 Address 0x51+W -> no ACK (sda stays high at the 9th clock); no wr_valid; busy stays 0.
REQ-032 START injected after 4 data bits of a write -> no wr_valid; the following full transaction SHALL complete normally.
REQ-033 Reset pulsed during RDATA bit 5 -> sda released within 1 clk; all registers SHALL read 0x00 afterwards.
REQ-034 With AUTO_INC_EN, write reg 0x0F then data 0x11, 0x22 -> regs[15]=0x11 and regs[0]=0x22; without AUTO_INC_EN -> regs[15]=0x22.
